cdcm8_tx_encoder: RTL and testbench

// - Upstream feeder of the CDCM-8 TX serializer. Takes the serial link bit stream (1 bit/clkDiv

---
 rtl/cdcm8_tx_encoder.sv | 116 +++++++++++
 tb/tb_cdcm8_tx_encoder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cdcm8_tx_encoder.sv
// CDCM-8 TX encoder: link bring-up sequencer and bit-to-waveform mapper
// feeding the serializer's parallel input, one waveform per clkDiv cycle.
module cdcm8_tx_encoder #(
  parameter int                kDevW        = 8,
  parameter logic [kDevW-1:0]  kIdlePattern = 8'hF0,
  parameter logic [kDevW-1:0]  kOnePattern  = 8'hF8,
  parameter logic [kDevW-1:0]  kZeroPattern = 8'hE0,
  parameter int                kTrainCycles = 64,
  parameter int                kCntW        = 16
) (
  input  logic             clkIn,
  input  logic             rstN,
  input  logic             txEnable,
  input  logic             scanFinished,
  input  logic             dataIn,
  input  logic             validIn,
  output logic             readyOut,
  output logic [kDevW-1:0] dOutToDevice,
  output logic             linkUp,
  output logic [kCntW-1:0] underrunCount
);

  localparam int kTcW =
    (kTrainCycles > 1) ? $clog2(kTrainCycles) : 1;
  localparam logic [kTcW-1:0] kTrainLast =
    kTcW'(kTrainCycles - 1);

  typedef enum logic [1:0] {
    S_WAIT,
    S_TRAIN,
    S_RUN
  } state_e;

  state_e           state_q, state_d;
  logic [kTcW-1:0]  train_q, train_d;
  logic             ready_q, ready_d;
  logic [kDevW-1:0] dout_q, dout_d;
  logic [kCntW-1:0] under_q, under_d;
  logic             link_ok;
  logic             accept;

  assign link_ok = txEnable && scanFinished;
  assign accept  = validIn && ready_q;

  always_comb begin
    state_d = state_q;
    train_d = train_q;
    unique case (state_q)
      S_WAIT: begin
        if (link_ok) begin
          state_d = S_TRAIN;
          train_d = '0;
        end
      end
      S_TRAIN: begin
        if (!link_ok) begin
          state_d = S_WAIT;
          train_d = '0;
        end else if (train_q == kTrainLast) begin
          state_d = S_RUN;
        end else begin
          train_d = train_q + 1'b1;
        end
      end
      S_RUN: begin
        if (!link_ok) state_d = S_WAIT;
      end
      default: begin
        state_d = S_WAIT;
        train_d = '0;
      end
    endcase
  end

  // readyOut is a look-ahead of the state so it is high in the first RUN cycle
  assign ready_d = (state_d == S_RUN);

  always_comb begin
    dout_d = kIdlePattern;
    unique case (1'b1)
      !accept:           dout_d = kIdlePattern;
      accept && dataIn:  dout_d = kOnePattern;
      accept && !dataIn: dout_d = kZeroPattern;
      default:           dout_d = kIdlePattern;
    endcase
  end

  always_comb begin
    under_d = under_q;
    if (ready_q && !validIn && (under_q != '1)) begin
      under_d = under_q + 1'b1;
    end
  end

  always_ff @(posedge clkIn or negedge rstN) begin
    if (!rstN) begin
      state_q <= S_WAIT;
      train_q <= '0;
      ready_q <= 1'b0;
      dout_q  <= kIdlePattern;
      under_q <= '0;
    end else begin
      state_q <= state_d;
      train_q <= train_d;
      ready_q <= ready_d;
      dout_q  <= dout_d;
      under_q <= under_d;
    end
  end

  assign readyOut      = ready_q;
  assign linkUp        = ready_q;
  assign dOutToDevice  = dout_q;
  assign underrunCount = under_q;

endmodule

// File: tb/tb_cdcm8_tx_encoder.sv
// Bench for cdcm8_tx_encoder: random traffic against a streak-count
// model of link bring-up plus directed literal checks.
module tb_cdcm8_tx_encoder;

  localparam int kTrain = 16;
  localparam int kCntW  = 4;
  localparam int kSat   = (1 << kCntW) - 1;

  logic             clkIn = 1'b0;
  logic             rstN = 1'b0;
  logic             txEnable = 1'b0;
  logic             scanFinished = 1'b0;
  logic             dataIn = 1'b0;
  logic             validIn = 1'b0;
  logic             readyOut;
  logic [7:0]       dOutToDevice;
  logic             linkUp;
  logic [kCntW-1:0] underrunCount;

  int total = 0;
  int bad   = 0;

  // model: link is up once en&&sf has been seen on kTrain+1 edges in a row
  int         m_streak = 0;
  logic       m_ready  = 1'b0;
  logic [7:0] m_dout   = 8'hF0;
  int         m_cnt    = 0;

  cdcm8_tx_encoder #(
    .kTrainCycles(kTrain),
    .kCntW(kCntW)
  ) dut (
    .clkIn(clkIn),
    .rstN(rstN),
    .txEnable(txEnable),
    .scanFinished(scanFinished),
    .dataIn(dataIn),
    .validIn(validIn),
    .readyOut(readyOut),
    .dOutToDevice(dOutToDevice),
    .linkUp(linkUp),
    .underrunCount(underrunCount)
  );

  always #5 clkIn = ~clkIn;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_streak = 0;
    m_ready  = 1'b0;
    m_dout   = 8'hF0;
    m_cnt    = 0;
  endtask

  task automatic model_edge(input logic en, sf, v, d);
    logic acc;
    acc = v && m_ready;
    m_dout = !acc ? 8'hF0 : (d ? 8'hF8 : 8'hE0);
    if (m_ready && !v && m_cnt < kSat) m_cnt++;
    if (en && sf) begin
      if (m_streak <= kTrain) m_streak++;
    end else begin
      m_streak = 0;
    end
    m_ready = (m_streak >= kTrain + 1);
  endtask

  task automatic compare();
    check("dout", int'(dOutToDevice), int'(m_dout));
    check("ready", int'(readyOut), int'(m_ready));
    check("linkup", int'(linkUp), int'(m_ready));
    check("underrun", int'(underrunCount), m_cnt);
  endtask

  task automatic step(input logic en, sf, v, d);
    @(negedge clkIn);
    txEnable = en;
    scanFinished = sf;
    validIn = v;
    dataIn = d;
    @(posedge clkIn);
    model_edge(en, sf, v, d);
    #1;
    compare();
  endtask

  task automatic step_rst(input logic en, sf, v, d);
    @(negedge clkIn);
    txEnable = en;
    scanFinished = sf;
    validIn = v;
    dataIn = d;
    #2 rstN = 1'b0;
    #1;
    model_reset();
    check("rst_dout", int'(dOutToDevice), 'hF0);
    check("rst_ready", int'(readyOut), 0);
    check("rst_cnt", int'(underrunCount), 0);
    #1 rstN = 1'b1;
    @(posedge clkIn);
    model_edge(en, sf, v, d);
    #1;
    compare();
  endtask

  initial begin
    int c0;
    logic bits [4];
    bits[0] = 1'b1;
    bits[1] = 1'b0;
    bits[2] = 1'b1;
    bits[3] = 1'b1;

    #12;
    check("por_dout", int'(dOutToDevice), 'hF0);
    check("por_ready", int'(readyOut), 0);
    check("por_cnt", int'(underrunCount), 0);
    @(negedge clkIn);
    rstN = 1'b1;

    for (int i = 0; i < 100; i++)
      step(1'b1, 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
    check("wait_ready", int'(readyOut), 0);
    check("wait_dout", int'(dOutToDevice), 'hF0);

    for (int i = 0; i <= kTrain; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      check("train_ready", int'(readyOut), (i == kTrain) ? 1 : 0);
      check("train_dout", int'(dOutToDevice), 'hF0);
    end

    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b1, bits[i]);
      check("b2b_dout", int'(dOutToDevice), bits[i] ? 'hF8 : 'hE0);
    end
    check("b2b_cnt", int'(underrunCount), 0);

    c0 = int'(underrunCount);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b1);
      check("gap_dout", int'(dOutToDevice), 'hF0);
    end
    check("gap_cnt", int'(underrunCount), c0 + 3);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("gap_next", int'(dOutToDevice), 'hE0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    check("sat_cnt", int'(underrunCount), kSat);

    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("drop_dout", int'(dOutToDevice), 'hE0);
    check("drop_ready", int'(readyOut), 0);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    check("drop_idle", int'(dOutToDevice), 'hF0);
    check("drop_hold", int'(underrunCount), kSat);
    for (int i = 0; i <= kTrain; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1);
      check("retrain_ready", int'(readyOut), (i == kTrain) ? 1 : 0);
    end

    step(1'b1, 1'b1, 1'b1, 1'b1);
    step_rst(1'b1, 1'b1, 1'b1, 1'b1);
    check("post_rst_ready", int'(readyOut), 0);

    for (int i = 0; i < 3000; i++) begin
      logic en, sf, v, d;
      en = ($urandom_range(99) != 0);
      sf = ($urandom_range(79) != 0);
      v  = ($urandom_range(9) < 7);
      d  = 1'($urandom_range(1));
      if ($urandom_range(499) == 0) step_rst(en, sf, v, d);
      else step(en, sf, v, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
